reg_scanner: RTL and testbench

REG_SCANNER -- requirements
Module: reg_scanner

---
 rtl/reg_scanner_pkg.sv | 18 +
 rtl/reg_scanner.sv | 138 +++++++++++++
 tb/tb_reg_scanner.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scanner_pkg.sv
// reg_scanner shared types and constants.
// State encoding and register-file geometry.
package reg_scanner_pkg;

   localparam int REG_COUNT = 32;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      PRESENT = 2'd2,
      FINISH  = 2'd3
   } state_e;

endpackage

// File: rtl/reg_scanner.sv
// reg_scanner: sweeps all 32 registers through one read port,
// presents each word on a valid/ready port and XORs the sweep.
module reg_scanner
   import reg_scanner_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] sweep_xor
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                mode_q, mode_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   sweep_xor_q, sweep_xor_d;

   // Next-state and next-output computation; abort overrides everything.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      rd_addr_d   = rd_addr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      sweep_xor_d = sweep_xor_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = READ;
               idx_d     = '0;
               mode_d    = mode;
               acc_d     = '0;
               rd_addr_d = '0;
            end
         end
         READ: begin
            out_data_d  = rd_data;
            out_addr_d  = idx_q;
            acc_d       = acc_q ^ rd_data;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
         end
         PRESENT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q != LAST_IDX) begin
                  idx_d     = idx_q + 1'b1;
                  rd_addr_d = idx_q + 1'b1;
                  state_d   = READ;
               end else begin
                  state_d     = FINISH;
                  done_d      = 1'b1;
                  sweep_xor_d = acc_q;
               end
            end
         end
         FINISH: begin
            if (mode_q) begin
               state_d   = READ;
               idx_d     = '0;
               rd_addr_d = '0;
               acc_d     = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         idx_d       = idx_q;
         acc_d       = acc_q;
         rd_addr_d   = rd_addr_q;
         out_valid_d = 1'b0;
         out_addr_d  = out_addr_q;
         out_data_d  = out_data_q;
         done_d      = 1'b0;
         sweep_xor_d = sweep_xor_q;
      end
   end

   // State and registered outputs, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         mode_q      <= 1'b0;
         acc_q       <= '0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         sweep_xor_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         sweep_xor_q <= sweep_xor_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign sweep_xor = sweep_xor_q;

endmodule

// File: tb/tb_reg_scanner.sv
// Testbench for reg_scanner: register file model, directed
// scenarios and randomized sweeps checked against a word-list model.
module tb_reg_scanner;

   logic        clk;
   logic        rst;
   logic        start;
   logic        mode;
   logic        abort;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        busy;
   logic        done;
   logic [31:0] sweep_xor;

   logic [31:0] rf [32];

   int compared;
   int mismatched;

   logic [4:0]  wa [$];
   logic [31:0] wd [$];
   int          wt [$];
   int          done_cnt;
   int          cyc;

   reg_scanner dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .abort     (abort),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .sweep_xor (sweep_xor)
   );

   assign rd_data = rf[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: observe at negedge, then return 1ns after posedge.
   task automatic tick();
      @(negedge clk);
      if (!rst && out_valid && out_ready && !abort) begin
         wa.push_back(out_addr);
         wd.push_back(out_data);
         wt.push_back(cyc);
      end
      if (done) done_cnt++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [31:0] model_xor();
      logic [31:0] x;
      x = '0;
      for (int i = 0; i < 32; i++) x = x ^ rf[i];
      return x;
   endfunction

   task automatic clear_obs();
      wa.delete();
      wd.delete();
      wt.delete();
      done_cnt = 0;
   endtask

   // Expected stream: registers 0..31 in order, repeated per sweep.
   task automatic check_words(input string tag, input int n);
      chk({tag, "_count"}, wa.size(), n);
      for (int i = 0; i < n && i < wa.size(); i++) begin
         chk({tag, "_addr"}, 32'(wa[i]), 32'(i % 32));
         chk({tag, "_data"}, wd[i], rf[i % 32]);
      end
   endtask

   initial begin
      int n;
      int stall;
      logic [31:0] exp_x;
      compared   = 0;
      mismatched = 0;
      cyc        = 0;
      rst        = 1'b1;
      start      = 1'b0;
      mode       = 1'b0;
      abort      = 1'b0;
      out_ready  = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;
      clear_obs();

      // Reset state
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_xor", sweep_xor, 0);
      chk("rst_rdaddr", rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single sweep of the linear pattern
      mode      = 1'b0;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("lat_busy", busy, 1);
      chk("lat_valid_read", out_valid, 0);
      chk("lat_rdaddr", rd_addr, 0);
      tick();
      chk("lat_valid", out_valid, 1);
      chk("lat_addr", out_addr, 0);
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         tick();
         n++;
      end
      tick();
      tick();
      check_words("lin", 32);
      if (wd.size() > 5) chk("lin_w5", wd[5], 32'h05050505);
      chk("lin_done", done_cnt, 1);
      chk("lin_xor", sweep_xor, model_xor());
      chk("lin_xor_zero", sweep_xor, 32'h0);
      chk("lin_busy", busy, 0);

      // Backpressure at word 7
      clear_obs();
      stall = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < 300) begin
         if (out_valid && out_addr == 5'd7 && stall < 10) begin
            out_ready = 1'b0;
            chk("stall_valid", out_valid, 1);
            chk("stall_addr", out_addr, 7);
            chk("stall_data", out_data, 32'h07070707);
            chk("stall_rdaddr", rd_addr, 7);
            stall++;
         end else begin
            out_ready = 1'b1;
         end
         tick();
         n++;
      end
      chk("stall_cycles", stall, 10);
      check_words("stall", 32);
      chk("stall_done", done_cnt, 1);

      // Random data, random ready, start pulses while busy
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      exp_x = model_xor();
      clear_obs();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < 600) begin
         out_ready = 1'($urandom_range(0, 1));
         start = out_valid && (out_addr == 5'd4 || out_addr == 5'd20);
         if (done) start = 1'b1;
         tick();
         n++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("rnd_busy", busy, 0);
      tick();
      tick();
      check_words("rnd", 32);
      chk("rnd_done", done_cnt, 1);
      chk("rnd_xor", sweep_xor, exp_x);
      chk("rnd_idle", busy, 0);

      // Continuous mode, single non-zero register
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[3] = 32'hDEADBEEF;
      clear_obs();
      mode  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      mode  = 1'b0;
      n = 0;
      while (done_cnt < 3 && n < 400) begin
         tick();
         n++;
      end
      chk("cont_done", done_cnt, 3);
      chk("cont_xor", sweep_xor, 32'hDEADBEEF);
      chk("cont_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("cont_abort_busy", busy, 0);
      chk("cont_abort_xor", sweep_xor, 32'hDEADBEEF);
      check_words("cont", 96);
      if (wt.size() > 33) begin
         chk("cont_gap_wrap", wt[32] - wt[31], 3);
         chk("cont_gap_word", wt[1] - wt[0], 2);
         chk("cont_gap_wrap2", wt[33] - wt[32], 2);
      end

      // Abort in IDLE is harmless
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_xor", sweep_xor, 32'hDEADBEEF);

      // Abort coinciding with the handshake at word 12
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      clear_obs();
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(out_valid && out_addr == 5'd12) && n < 100) begin
         tick();
         n++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abt_busy", busy, 0);
      chk("abt_valid", out_valid, 0);
      chk("abt_done", done, 0);
      chk("abt_xor", sweep_xor, 32'hDEADBEEF);
      check_words("abt", 12);
      tick();
      tick();
      tick();
      chk("abt_nodone", done_cnt, 0);
      chk("abt_idle", busy, 0);

      // Reset in the middle of word 9
      clear_obs();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(out_valid && out_addr == 5'd9) && n < 100) begin
         tick();
         n++;
      end
      chk("mid_pre_addr", out_addr, 9);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_valid", out_valid, 0);
      chk("mid_addr", out_addr, 0);
      chk("mid_data", out_data, 0);
      chk("mid_done", done, 0);
      chk("mid_xor", sweep_xor, 0);
      chk("mid_rdaddr", rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_nodone", done_cnt, 0);
      clear_obs();
      out_ready = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("post_valid", out_valid, 1);
      chk("post_addr", out_addr, 0);
      chk("post_data", out_data, rf[0]);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("post_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
